sd_demod_cic2: RTL and testbench
================================

SD_DEMOD_CIC2 -- requirements
Module: sd_demod_cic2

Interface
REQ-001 SHALL have parameter NUM_MODULATED_BITS, default 12, output word width N.
REQ-002 SHALL have parameter DECIM_LOG2, default 6, with decimation ratio R = 2^DECIM_LOG2; legal only when 2*DECIM_LOG2 >= N.
REQ-003 SHALL have clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have global_rst  input  1  the reset, which is asynchronous and active-high.
REQ-005 SHALL have in  input  1  the sigma-delta bitstream (1 = full scale, 0 = zero).
REQ-006 SHALL have in_en  input  1  the sample enable; a bit is consumed only in cycles where in_en=1.
REQ-007 SHALL have sync_clr  input  1  the synchronous restart of the filter and the decimation phase.
REQ-008 SHALL have out  output  N  the decimated, scaled, saturated word.
REQ-009 SHALL have out_valid  output  1  a one-cycle strobe qualifying out.
REQ-010 SHALL have out_overrange  output  1  set when the current out value was saturated; held with out.

Function
REQ-011 SHALL implement a second-order CIC: two integrators, a decimate-by-R stage, and two combs, all unsigned, W = 2*DECIM_LOG2+1 bits, with modulo-2^W wrap (no overflow detection inside).
REQ-012 SHALL update the integrators on accepted samples only: i1 <= i1 + in; i2 <= i2 + i1 (old i1).
REQ-013 SHALL count accepted samples with a DECIM_LOG2-bit phase counter; the sample taking the counter from R-1 to 0 is the decimation event.
REQ-014 SHALL, on a decimation event, capture the post-update i2 as s and compute c1 = s - s_prev and c2 = c1 - c1_prev (mod 2^W) in the next cycle, then update s_prev and c1_prev.
REQ-015 SHALL compute y = c2 >> (2*DECIM_LOG2 - N); if y > 2^N-1, out = 2^N-1 and out_overrange = 1; otherwise out = y and out_overrange = 0.
REQ-016 SHALL assert out, out_overrange and out_valid at the second rising edge after the edge accepting the event sample; out_valid is high for exactly one cycle, and out and out_overrange hold until the next valid.
REQ-017 SHALL suppress out_valid for the first 2 decimation events after reset or sync_clr (warm-up state FILL0 -> FILL1 -> RUN); out still updates internally.
REQ-018 SHALL, with in_en=0, freeze the integrators, phase and warm-up state; any output already in the pipeline still completes.
REQ-019 SHALL, on sync_clr=1, clear the integrators, phase, comb history and warm-up state to FILL0, and discard any in-flight result (no out_valid from it); sync_clr has priority over in_en in the same cycle.
REQ-020 SHALL leave out and out_overrange unchanged on sync_clr.
REQ-021 SHALL tolerate in_en gaps of any length without changing the computed results.

Reset
REQ-022 SHALL, while global_rst=1, asynchronously force out=0, out_valid=0, out_overrange=0, all integrators, combs and history to 0, the phase to 0, and the warm-up state to FILL0.
REQ-023 SHALL resume at the first rising edge with global_rst=0, treating that edge's sample as phase 0.
REQ-024 SHALL, if reset asserts mid-frame or mid-pipeline, drop the pending result without any out_valid.

Verification (N=12, DECIM_LOG2=6, R=64)
REQ-025 SHALL cover: reset, then in=0 and in_en=1 continuous -> first out_valid 2 cycles after the 192nd sample, then every 64 cycles, with out=0 and overrange=0.
REQ-026 SHALL cover: in=1 continuous -> steady state out=4095 and out_overrange=1 (c2=4096 saturated).
REQ-027 SHALL cover: alternating 1/0 of either phase -> steady state out=2048 and overrange=0.
REQ-028 SHALL cover: alternating stream with in_en toggled randomly at 50% -> same outputs as REQ-027, with out_valid spacing equal to 64 accepted samples.
REQ-029 SHALL cover: sync_clr in the cycle after a decimation event -> no out_valid for that event; the next valid comes after 192 further accepted samples; out holds its old value meanwhile.
REQ-030 SHALL cover: global_rst pulsed mid-frame (not clock-aligned) -> outputs 0 immediately, and warm-up restarts as in REQ-025.

Source files
------------

// File: rtl/sd_demod_cic2.sv
// Second-order CIC decimator for a 1-bit sigma-delta stream.
// The output is scaled to NUM_MODULATED_BITS and saturated, with a two-event warm-up after any restart.
module sd_demod_cic2 #(
    parameter int unsigned NUM_MODULATED_BITS = 12,
    parameter int unsigned DECIM_LOG2         = 6
) (
    input  logic                          clk,
    input  logic                          global_rst,
    input  logic                          in,
    input  logic                          in_en,
    input  logic                          sync_clr,
    output logic [NUM_MODULATED_BITS-1:0] out,
    output logic                          out_valid,
    output logic                          out_overrange
);

    localparam int unsigned N     = NUM_MODULATED_BITS;
    localparam int unsigned L     = DECIM_LOG2;
    localparam int unsigned W     = 2 * L + 1;
    localparam int unsigned SHIFT = 2 * L - N;
    localparam int unsigned YW    = W - SHIFT;

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } warm_t;

    warm_t          r_state;
    logic [W-1:0]   r_i1;
    logic [W-1:0]   r_i2;
    logic [W-1:0]   r_s;
    logic [W-1:0]   r_s_prev;
    logic [W-1:0]   r_c1_prev;
    logic [W-1:0]   r_c2;
    logic [L-1:0]   r_phase;
    logic           r_s_evt;
    logic           r_s_vld;
    logic           r_c2_vld;
    logic [N-1:0]   r_out;
    logic           r_out_valid;
    logic           r_out_ovr;

    logic           w_evt;
    logic [W-1:0]   w_i1_nxt;
    logic [W-1:0]   w_i2_nxt;
    logic [W-1:0]   w_c1;
    logic [W-1:0]   w_c2;
    logic [YW-1:0]  w_y;

    assign w_evt    = in_en & (&r_phase);
    assign w_i1_nxt = r_i1 + W'(in);
    assign w_i2_nxt = r_i2 + r_i1;
    assign w_c1     = r_s - r_s_prev;
    assign w_c2     = w_c1 - r_c1_prev;
    assign w_y      = r_c2[W-1:SHIFT];

    assign out           = r_out;
    assign out_valid     = r_out_valid;
    assign out_overrange = r_out_ovr;

    // Pipeline: event edge captures s, next edge runs the combs, next edge drives out.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            r_state     <= FILL0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_s         <= '0;
            r_s_prev    <= '0;
            r_c1_prev   <= '0;
            r_c2        <= '0;
            r_phase     <= '0;
            r_s_evt     <= 1'b0;
            r_s_vld     <= 1'b0;
            r_c2_vld    <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_ovr   <= 1'b0;
        end else if (sync_clr) begin
            r_state     <= FILL0;
            r_i1        <= '0;
            r_i2        <= '0;
            r_s         <= '0;
            r_s_prev    <= '0;
            r_c1_prev   <= '0;
            r_c2        <= '0;
            r_phase     <= '0;
            r_s_evt     <= 1'b0;
            r_s_vld     <= 1'b0;
            r_c2_vld    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_c2_vld;
            if (r_c2_vld) begin
                r_out     <= w_y[N] ? {N{1'b1}} : w_y[N-1:0];
                r_out_ovr <= w_y[N];
            end

            r_c2_vld <= r_s_evt & r_s_vld;
            if (r_s_evt) begin
                r_c2      <= w_c2;
                r_s_prev  <= r_s;
                r_c1_prev <= w_c1;
            end

            r_s_evt <= w_evt;
            r_s_vld <= w_evt && (r_state == RUN);

            if (in_en) begin
                r_i1    <= w_i1_nxt;
                r_i2    <= w_i2_nxt;
                r_phase <= r_phase + L'(1);
                if (w_evt) begin
                    r_s <= w_i2_nxt;
                    case (r_state)
                        FILL0:   r_state <= FILL1;
                        FILL1:   r_state <= RUN;
                        default: r_state <= RUN;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_demod_cic2.sv
// Directed bench for sd_demod_cic2 (N=12, R=64): warm-up timing, DC/alternating levels,
// enable gaps, sync_clr discard and asynchronous mid-frame reset.
module tb_sd_demod_cic2;

    logic        clk = 1'b0;
    logic        global_rst;
    logic        in_b;
    logic        in_en;
    logic        sync_clr;
    logic [11:0] out;
    logic        out_valid;
    logic        out_overrange;

    int total = 0;
    int bad   = 0;

    int since;
    bit q1, q2;
    int exp_out;
    bit exp_ovr;
    int mode_val;
    bit mode_ovr;
    bit alt;

    sd_demod_cic2 #(.NUM_MODULATED_BITS(12), .DECIM_LOG2(6)) dut (
        .clk          (clk),
        .global_rst   (global_rst),
        .in           (in_b),
        .in_en        (in_en),
        .sync_clr     (sync_clr),
        .out          (out),
        .out_valid    (out_valid),
        .out_overrange(out_overrange)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the timing model, check outputs at the falling edge.
    task automatic step(input bit b, input bit en, input bit clr);
        bit evt;
        bit ev;
        in_b     = b;
        in_en    = en;
        sync_clr = clr;
        evt = !clr && en && (((since + 1) % 64) == 0) && ((since + 1) >= 192);
        @(posedge clk);
        ev = clr ? 1'b0 : q2;
        q2 = clr ? 1'b0 : q1;
        q1 = evt;
        if (clr) since = 0;
        else if (en) since++;
        if (ev) begin
            exp_out = mode_val;
            exp_ovr = mode_ovr;
        end
        @(negedge clk);
        chk("valid", 32'(out_valid), 32'(ev));
        chk("out", 32'(out), 32'(exp_out));
        chk("ovr", 32'(out_overrange), 32'(exp_ovr));
    endtask

    task automatic restart(input int v, input bit o);
        mode_val = v;
        mode_ovr = o;
        step(1'b0, 1'b1, 1'b1);
    endtask

    task automatic run_const(input int n, input bit b);
        repeat (n) step(b, 1'b1, 1'b0);
    endtask

    task automatic run_alt(input int n, input bit rnd);
        int acc;
        int cyc;
        bit en;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 4 * n + 200) begin
            en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step(alt, en, 1'b0);
            if (en) begin
                alt = ~alt;
                acc++;
            end
            cyc++;
        end
        chk("alt_budget", 32'(acc), 32'(n));
    endtask

    initial begin
        global_rst = 1'b1;
        in_b       = 1'b0;
        in_en      = 1'b0;
        sync_clr   = 1'b0;
        since      = 0;
        q1         = 1'b0;
        q2         = 1'b0;
        exp_out    = 0;
        exp_ovr    = 1'b0;
        mode_val   = 0;
        mode_ovr   = 1'b0;
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovr", 32'(out_overrange), 32'd0);
        @(negedge clk);
        global_rst = 1'b0;

        // zero input: first valid two edges after sample 192, then every 64
        run_const(192 + 128 + 4, 1'b0);

        // full-scale input saturates
        restart(4095, 1'b1);
        run_const(192 + 128, 1'b1);

        // sync_clr right after a decimation event discards it; out holds 4095
        while ((since % 64) != 0) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        run_const(192 + 70, 1'b1);

        // alternating, both phases
        restart(2048, 1'b0);
        alt = 1'b1;
        run_alt(192 + 128, 1'b0);
        restart(2048, 1'b0);
        alt = 1'b0;
        run_alt(192 + 128, 1'b0);

        // alternating with random enable gaps
        restart(2048, 1'b0);
        alt = 1'b1;
        run_alt(192 + 192, 1'b1);

        // full scale again, then asynchronous reset mid-frame
        restart(4095, 1'b1);
        run_const(192 + 64 + 20, 1'b1);
        chk("pre_rst_out", 32'(out), 32'd4095);
        @(posedge clk);
        #3 global_rst = 1'b1;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ovr", 32'(out_overrange), 32'd0);
        @(negedge clk);
        @(negedge clk);
        global_rst = 1'b0;
        since    = 0;
        q1       = 1'b0;
        q2       = 1'b0;
        exp_out  = 0;
        exp_ovr  = 1'b0;
        mode_val = 0;
        mode_ovr = 1'b0;
        run_const(192 + 64 + 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
